max_sort8: RTL

MAX_SORT8 -- requirements
Module: max_sort8

---
 rtl/max_sort8.sv | 124 ++++++++++++
 1 files changed

// File: rtl/max_sort8.sv
// Batch sorter: loads up to 8 entries, then repeatedly scans for the
// maximum and emits it, ties going to the lowest load slot.
module max_sort8 #(
  parameter int DATA_BITS = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [DATA_BITS-1:0] IN_DATA,
  input  logic                 IN_LAST,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [DATA_BITS-1:0] OUT_DATA,
  output logic [2:0]           OUT_NUMBER,
  output logic                 OUT_LAST,
  output logic                 BUSY
);

  typedef enum logic [1:0] {
    LOAD,
    SCAN,
    EMIT
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [8];
  logic [7:0]           present_q;
  logic [3:0]           count_q;
  logic [2:0]           wr_slot_q;
  logic [2:0]           scan_idx_q;
  logic [2:0]           best_num_q;
  logic [DATA_BITS-1:0] best_val_q;
  logic                 best_found_q;
  logic                 in_fire;
  logic                 out_fire;
  logic                 load_done;
  logic                 rescan;
  logic                 take;

  assign in_fire   = IN_VALID && IN_READY;
  assign out_fire  = OUT_VALID && OUT_READY;
  assign load_done = in_fire && (IN_LAST || wr_slot_q == 3'd7);
  assign rescan    = out_fire && (count_q != 4'd1);

  // Strict compare keeps the earlier slot on ties.
  assign take = (state_q == SCAN) && present_q[scan_idx_q] &&
                (!best_found_q || mem_q[scan_idx_q] > best_val_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    IN_READY   = 1'b0;
    OUT_VALID  = 1'b0;
    OUT_DATA   = '0;
    OUT_NUMBER = '0;
    OUT_LAST   = 1'b0;
    BUSY       = 1'b1;
    unique case (state_q)
      LOAD: begin
        IN_READY = 1'b1;
        BUSY     = 1'b0;
        if (IN_VALID && (IN_LAST || wr_slot_q == 3'd7))
          state_d = SCAN;
      end
      SCAN: begin
        if (scan_idx_q == 3'd7)
          state_d = EMIT;
      end
      EMIT: begin
        OUT_VALID  = 1'b1;
        OUT_DATA   = best_val_q;
        OUT_NUMBER = best_num_q;
        OUT_LAST   = (count_q == 4'd1);
        if (OUT_READY)
          state_d = (count_q == 4'd1) ? LOAD : SCAN;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      present_q    <= '0;
      count_q      <= '0;
      wr_slot_q    <= '0;
      scan_idx_q   <= '0;
      best_num_q   <= '0;
      best_val_q   <= '0;
      best_found_q <= 1'b0;
    end else begin
      if (in_fire) begin
        present_q[wr_slot_q] <= 1'b1;
        count_q              <= count_q + 4'd1;
        wr_slot_q            <= load_done ? 3'd0 : wr_slot_q + 3'd1;
      end
      if (state_q == SCAN)
        scan_idx_q <= scan_idx_q + 3'd1;
      if (take) begin
        best_val_q   <= mem_q[scan_idx_q];
        best_num_q   <= scan_idx_q;
        best_found_q <= 1'b1;
      end
      if (out_fire) begin
        present_q[best_num_q] <= 1'b0;
        count_q               <= count_q - 4'd1;
      end
      if (load_done || rescan) begin
        scan_idx_q   <= '0;
        best_found_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (in_fire)
      mem_q[wr_slot_q] <= IN_DATA;
  end

endmodule
